pot_scan_sched: RTL and testbench

Round-robin scheduler that owns the A2D conversion interface and continuously sweeps the six equalizer slide pots (LP, B1, B2, B3, HP, volume). It issues one conversion request at a time to the A2D SPI master, which drives the ADC128S. It captures each 12-bit result into that pot's holding register. The registers feed the band-gain and volume multipliers directly. It also flags stale or hung conversions.

---
 rtl/pot_scan_sched.sv | 150 +++++++++++++++
 tb/tb_pot_scan_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pot_scan_sched.sv
// pot_scan_sched: round-robin A2D sweep of the six EQ slide pots.
// clk/rst_n/en in; strt_cnv/chnnl to A2D, cnv_cmplt/res from it;
// six 12-bit pot regs, pots_vld, sweep_done, tmo_err out.
module pot_scan_sched #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic [11:0] LP_pot,
  output logic [11:0] B1_pot,
  output logic [11:0] B2_pot,
  output logic [11:0] B3_pot,
  output logic [11:0] HP_pot,
  output logic [11:0] volume,
  output logic        pots_vld,
  output logic        sweep_done,
  output logic        tmo_err
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    GAP
  } state_t;

  state_t        state;
  logic [2:0]    slot;
  logic [2:0]    slot_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [GW-1:0] gap_cnt;
  logic [5:0]    capt;
  logic [5:0]    capt_nxt;
  logic          tmo_hit;
  logic [11:0]   pot_q [6];

  function automatic logic [2:0] chan_of(
    input logic [2:0] s
  );
    logic [2:0] c;
    c = 3'd1;
    unique case (s)
      3'd0:    c = 3'd1;
      3'd1:    c = 3'd0;
      3'd2:    c = 3'd4;
      3'd3:    c = 3'd2;
      3'd4:    c = 3'd3;
      3'd5:    c = 3'd7;
      default: c = 3'd1;
    endcase
    return c;
  endfunction

  assign slot_nxt = (slot == 3'd5) ? 3'd0 : slot + 3'd1;
  assign capt_nxt = capt | (6'd1 << slot);
  assign tmo_hit  = (tmo_cnt == TMO_LAST);

  assign LP_pot = pot_q[0];
  assign B1_pot = pot_q[1];
  assign B2_pot = pot_q[2];
  assign B3_pot = pot_q[3];
  assign HP_pot = pot_q[4];
  assign volume = pot_q[5];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      slot       <= 3'd0;
      chnnl      <= 3'd1;
      strt_cnv   <= 1'b0;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
      capt       <= '0;
      pots_vld   <= 1'b0;
      sweep_done <= 1'b0;
      tmo_err    <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        pot_q[i] <= '0;
      end
    end else begin
      strt_cnv   <= 1'b0;
      sweep_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en) begin
            state    <= START;
            strt_cnv <= 1'b1;
          end
        end
        START: begin
          state   <= WAIT;
          tmo_cnt <= '0;
        end
        WAIT: begin
          // completion wins over a same-cycle timeout
          if (cnv_cmplt || tmo_hit) begin
            if (cnv_cmplt) begin
              for (int i = 0; i < 6; i++) begin
                if (slot == 3'(i)) begin
                  pot_q[i] <= res;
                end
              end
              capt     <= capt_nxt;
              pots_vld <= &capt_nxt;
            end else begin
              tmo_err <= 1'b1;
            end
            slot       <= slot_nxt;
            chnnl      <= chan_of(slot_nxt);
            gap_cnt    <= GAP_LOAD;
            sweep_done <= (slot == 3'd5);
            state      <= GAP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        GAP: begin
          // counts GAP_CYCLES down to zero inclusive, so the
          // next request lands GAP_CYCLES+1 clocks after done
          if (gap_cnt == '0) begin
            if (en) begin
              state    <= START;
              strt_cnv <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pot_scan_sched.sv
// tb_pot_scan_sched: directed bench with A2D responder,
// timeline reference model and per-cycle output compare.
module tb_pot_scan_sched;

  localparam int LAT = 40;
  localparam int GAP = 16;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic [11:0] LP_pot, B1_pot, B2_pot;
  logic [11:0] B3_pot, HP_pot, volume;
  logic        pots_vld, sweep_done, tmo_err;

  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int suppress_ch = -1;
  int stray_req = 0;
  logic [7:0] tag = 8'h00;
  int chan_tbl [6] = '{1, 0, 4, 2, 3, 7};

  pot_scan_sched #(
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .strt_cnv(strt_cnv),
    .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt),
    .res(res),
    .LP_pot(LP_pot),
    .B1_pot(B1_pot),
    .B2_pot(B2_pot),
    .B3_pot(B3_pot),
    .HP_pot(HP_pot),
    .volume(volume),
    .pots_vld(pots_vld),
    .sweep_done(sweep_done),
    .tmo_err(tmo_err)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic lost(input string nm);
    checks++;
    fails++;
    $display("FAIL %s actual=no_event required=event cyc=%0d",
             nm, cyc);
  endtask

  // A2D responder: completes LAT clocks after each start,
  // stays silent on the suppressed channel, injects strays.
  initial begin : a2d
    int rsp_cnt;
    int stray_ack;
    logic [11:0] rsp_val;
    rsp_cnt = 0;
    stray_ack = 0;
    rsp_val = '0;
    cnv_cmplt = 1'b0;
    res = '0;
    forever begin
      @(negedge clk);
      cnv_cmplt = 1'b0;
      if (!rst_n) begin
        rsp_cnt = 0;
      end else if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          cnv_cmplt = 1'b1;
          res = rsp_val;
        end
      end else if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        cnv_cmplt = 1'b1;
        res = 12'hABC;
      end
      if (rst_n && strt_cnv &&
          int'(chnnl) != suppress_ch) begin
        rsp_cnt = LAT - 1;
        rsp_val = {1'b0, chnnl, tag};
      end
    end
  end

  // Reference: a timeline of conversions. Each start ends
  // LAT clocks later (or 1+TMO on a silent channel); the next
  // start follows GAP+1 clocks after the end if en is high.
  typedef enum {M_IDLE, M_BUSY, M_GAP} mph_t;

  initial begin : model
    mph_t        mph;
    int          m_slot, conv_end, gap_end;
    bit          conv_ok, m_tmo, en_smp, rst_smp;
    bit          s_exp, d_exp;
    bit   [5:0]  m_capt;
    logic [11:0] conv_val;
    logic [11:0] m_pot [6];
    mph = M_IDLE;
    m_slot = 0;
    conv_end = 0;
    gap_end = 0;
    conv_ok = 0;
    m_tmo = 0;
    en_smp = 0;
    rst_smp = 0;
    m_capt = '0;
    conv_val = '0;
    for (int i = 0; i < 6; i++) m_pot[i] = '0;
    forever begin
      @(negedge clk);
      s_exp = 0;
      d_exp = 0;
      if (!rst_smp) begin
        mph = M_IDLE;
        m_slot = 0;
        m_tmo = 0;
        m_capt = '0;
        for (int i = 0; i < 6; i++) m_pot[i] = '0;
      end else if (mph == M_BUSY && cyc == conv_end) begin
        if (conv_ok) begin
          m_pot[m_slot] = conv_val;
          m_capt[m_slot] = 1'b1;
        end else begin
          m_tmo = 1;
        end
        d_exp = (m_slot == 5);
        m_slot = (m_slot + 1) % 6;
        mph = M_GAP;
        gap_end = cyc + GAP + 1;
      end else if ((mph == M_IDLE && en_smp) ||
                   (mph == M_GAP && cyc == gap_end &&
                    en_smp)) begin
        s_exp = 1;
        mph = M_BUSY;
        conv_ok = chan_tbl[m_slot] != suppress_ch;
        conv_val = {1'b0, 3'(chan_tbl[m_slot]), tag};
        conv_end = cyc + (conv_ok ? LAT : 1 + TMO);
      end else if (mph == M_GAP && cyc == gap_end) begin
        mph = M_IDLE;
      end
      chk("strt_cnv", int'(strt_cnv), int'(s_exp));
      chk("chnnl", int'(chnnl), chan_tbl[m_slot]);
      chk("sweep_done", int'(sweep_done), int'(d_exp));
      chk("pots_vld", int'(pots_vld), int'(&m_capt));
      chk("tmo_err", int'(tmo_err), int'(m_tmo));
      chk("LP_pot", int'(LP_pot), int'(m_pot[0]));
      chk("B1_pot", int'(B1_pot), int'(m_pot[1]));
      chk("B2_pot", int'(B2_pot), int'(m_pot[2]));
      chk("B3_pot", int'(B3_pot), int'(m_pot[3]));
      chk("HP_pot", int'(HP_pot), int'(m_pot[4]));
      chk("volume", int'(volume), int'(m_pot[5]));
      en_smp = en;
      rst_smp = rst_n;
    end
  end

  task automatic wait_strt(input logic [2:0] ch,
                           input string nm,
                           output int at);
    bit hit;
    hit = 0;
    for (int n = 0; n < 3000 && !hit; n++) begin
      @(negedge clk);
      hit = strt_cnv && (chnnl == ch);
    end
    at = cyc;
    if (!hit) lost(nm);
  endtask

  // sel 0: sweep_done, sel 1: tmo_err
  task automatic wait_hi(input int sel, input string nm,
                         output int at);
    bit hit;
    hit = 0;
    for (int n = 0; n < 3000 && !hit; n++) begin
      @(negedge clk);
      hit = (sel == 0) ? sweep_done : tmo_err;
    end
    at = cyc;
    if (!hit) lost(nm);
  endtask

  initial begin : stim
    int t0, t1, r;
    bit hit;
    rst_n = 1'b0;
    en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_chnnl", int'(chnnl), 1);
    chk("rst_strt", int'(strt_cnv), 0);
    chk("rst_lp", int'(LP_pot), 0);
    chk("rst_vol", int'(volume), 0);
    chk("rst_vld", int'(pots_vld), 0);
    chk("rst_tmo", int'(tmo_err), 0);

    // first sweep: channel x 0x100
    @(posedge clk);
    #1 rst_n = 1'b1;
    r = cyc;
    wait_strt(3'd1, "first_strt", t0);
    chk("first_strt_lat", t0 - r, 1);
    wait_strt(3'd0, "strt_b1", t1);
    chk("strt_spacing", t1 - t0, 57);
    wait_hi(0, "sweep1_done", t1);
    chk("s1_lp", int'(LP_pot), 'h100);
    chk("s1_b1", int'(B1_pot), 'h000);
    chk("s1_b2", int'(B2_pot), 'h400);
    chk("s1_b3", int'(B3_pot), 'h200);
    chk("s1_hp", int'(HP_pot), 'h300);
    chk("s1_vol", int'(volume), 'h700);
    chk("s1_vld", int'(pots_vld), 1);

    // stray completion during GAP after the LP capture
    hit = 0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(posedge clk);
      hit = cnv_cmplt;
    end
    if (!hit) lost("lp2_cmplt");
    #1 stray_req++;
    repeat (5) @(negedge clk);
    chk("stray_lp", int'(LP_pot), 'h100);
    chk("stray_chnnl", int'(chnnl), 0);
    @(posedge clk);
    #1 tag = 8'h5A;

    // drop en during the B2 conversion
    wait_strt(3'd4, "strt_b2", t0);
    @(posedge clk);
    #1 en = 1'b0;
    repeat (100) @(negedge clk);
    chk("en_off_chnnl", int'(chnnl), 2);
    chk("en_off_strt", int'(strt_cnv), 0);
    chk("en_off_b2", int'(B2_pot), 'h45A);
    chk("en_off_b1", int'(B1_pot), 'h05A);
    @(posedge clk);
    #1 en = 1'b1;
    r = cyc;
    wait_strt(3'd2, "en_on_strt", t0);
    chk("en_on_lat", t0 - r, 1);

    // reset mid-WAIT of the HP conversion
    wait_strt(3'd3, "strt_hp", t0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    suppress_ch = 2;
    @(posedge clk);
    #1 rst_n = 1'b1;
    r = cyc;
    @(negedge clk);
    chk("mid_rst_lp", int'(LP_pot), 0);
    chk("mid_rst_b2", int'(B2_pot), 0);
    chk("mid_rst_vld", int'(pots_vld), 0);
    chk("mid_rst_tmo", int'(tmo_err), 0);
    chk("mid_rst_chnnl", int'(chnnl), 1);
    wait_strt(3'd1, "restart_lp", t0);
    chk("restart_lat", t0 - r, 1);

    // B3 never answers: timeout
    wait_strt(3'd2, "strt_b3", t0);
    wait_hi(1, "tmo_rise", t1);
    chk("tmo_latency", t1 - t0, 65);
    chk("tmo_b3", int'(B3_pot), 0);
    wait_hi(0, "sweep_tmo_done", t1);
    chk("tmo_sw_vld", int'(pots_vld), 0);
    chk("tmo_sw_b3", int'(B3_pot), 0);
    chk("tmo_sw_hp", int'(HP_pot), 'h35A);
    chk("tmo_sw_vol", int'(volume), 'h75A);
    @(posedge clk);
    #1 suppress_ch = -1;
    wait_hi(0, "sweep_ok_done", t1);
    chk("fin_vld", int'(pots_vld), 1);
    chk("fin_b3", int'(B3_pot), 'h25A);
    chk("fin_tmo", int'(tmo_err), 1);
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
